// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: a burst of nbits SCLK cycles at a programmable half-period,
// with registered edge, sample and shift strobes and busy/done handshakes.
module spi_sclk_gen #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic [CNT_WIDTH-1:0] nbits,
  input  logic                 cpol,
  input  logic                 cpha,
  output logic                 sclk,
  output logic                 lead_stb,
  output logic                 trail_stb,
  output logic                 sample_stb,
  output logic                 shift_stb,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);

  state_e               state_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] hcnt_q;
  logic [CNT_WIDTH-1:0] nbits_q;
  logic [CNT_WIDTH:0]   edge_q;
  logic [CNT_WIDTH:0]   edge_nxt;
  logic                 cpol_q;
  logic                 cpha_q;
  logic                 half_done;
  logic                 nxt_lead;

  assign edge_nxt  = edge_q + 1'b1;
  assign half_done = (hcnt_q == div_q - DivOne);
  // Odd edge numbers are leading edges.
  assign nxt_lead  = edge_nxt[0];

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= DivOne;
      hcnt_q     <= '0;
      nbits_q    <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk       <= 1'b0;
      lead_stb   <= 1'b0;
      trail_stb  <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lead_stb   <= 1'b0;
      trail_stb  <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      done       <= 1'b0;
      case (state_q)
        StIdle: begin
          sclk   <= cpol;
          busy   <= 1'b0;
          hcnt_q <= '0;
          edge_q <= '0;
          if (start) begin
            div_q   <= (div_val == '0) ? DivOne : div_val;
            nbits_q <= nbits;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            if (nbits == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
            sclk    <= cpol_q;
            busy    <= 1'b0;
          end else if (half_done) begin
            hcnt_q     <= '0;
            edge_q     <= edge_nxt;
            sclk       <= ~sclk;
            lead_stb   <= nxt_lead;
            trail_stb  <= ~nxt_lead;
            sample_stb <= cpha_q ? ~nxt_lead : nxt_lead;
            shift_stb  <= cpha_q ? nxt_lead : ~nxt_lead;
            if (edge_nxt == {nbits_q, 1'b0}) state_q <= StDone;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          if (abort) sclk <= cpol_q;
          else       done <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Randomised self-checking bench for spi_sclk_gen against a closed-form timing model.
module tb_spi_sclk_gen;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] div_val;
  logic [5:0] nbits;
  logic       cpol;
  logic       cpha;
  logic       sclk, lead_stb, trail_stb, sample_stb, shift_stb, busy, done;
  logic [6:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  spi_sclk_gen #(.DIV_WIDTH(8), .CNT_WIDTH(6)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .div_val    (div_val),
    .nbits      (nbits),
    .cpol       (cpol),
    .cpha       (cpha),
    .sclk       (sclk),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {sclk, lead_stb, trail_stb, sample_stb, shift_stb, busy, done};

  // Expected {sclk,lead,trail,sample,shift,busy,done} t cycles after the start posedge.
  function automatic logic [6:0] model(int t, int d, int n, bit cp, bit ch, int ab);
    int k, edges;
    bit is_edge, lead, trail, sc, bsy, dn;
    if (ab > 0 && t >= ab) return {cp, 6'b0};
    k       = t / d;
    edges   = (k > 2 * n) ? 2 * n : k;
    sc      = cp ^ (edges % 2 == 1);
    is_edge = (t > 0) && (t % d == 0) && (k <= 2 * n);
    lead    = is_edge && (k % 2 == 1);
    trail   = is_edge && (k % 2 == 0);
    bsy     = (n > 0) && (t <= 2 * n * d);
    dn      = (t == 2 * n * d + 1);
    return {sc, lead, trail, ch ? trail : lead, ch ? lead : trail, bsy, dn};
  endfunction

  // glitch: 0 none, >0 pulse start at that posedge, <0 random start pulses while busy.
  task automatic run_burst(input string name, input int dv, input int nb, input bit cp,
                           input bit ch, input int ab, input int glitch, input int tail,
                           input bit scramble);
    int d, last, tend;
    logic [6:0] exp;
    d    = (dv == 0) ? 1 : dv;
    tend = 2 * nb * d;
    last = ((ab > 0) ? ab : tend + 1) + tail;
    div_val = 8'(dv); nbits = 6'(nb); cpol = cp; cpha = ch; abort = 1'b0; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      if (t > 0) begin
        @(posedge clk_in); #1;
      end
      exp = model(t, d, nb, cp, ch, ab);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s t=%0d got=%b exp=%b (sclk,lead,trail,sample,shift,busy,done)",
                 name, t, obs, exp);
      end
      start = 1'b0;
      abort = (ab > 0 && t + 1 == ab);
      if (scramble && t + 1 <= tend && !(ab > 0 && t + 1 >= ab)) begin
        div_val = 8'($urandom); nbits = 6'($urandom);
        cpol = 1'($urandom); cpha = 1'($urandom);
      end else begin
        div_val = 8'(dv); nbits = 6'(nb); cpol = cp; cpha = ch;
      end
      if (glitch > 0 && t + 1 == glitch) start = 1'b1;
      if (glitch < 0 && t + 1 <= tend + 1 && (ab == 0 || t + 1 <= ab) &&
          $urandom_range(0, 3) == 0) start = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; div_val = 8'd4; nbits = 6'd8;
    cpol = 1'b1; cpha = 1'b0;
    #1;
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++; $display("FAIL reset_async got=%b exp=%b", obs, 7'b0);
    end
    repeat (2) @(posedge clk_in);
    #1;
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++; $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0);
    end
    rst = 1'b0;
    @(posedge clk_in); #1;
    n_checks++;
    if (obs !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_release got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  task automatic test_idle_follow();
    cpol = 1'b0;
    @(posedge clk_in); #1;
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++; $display("FAIL idle_cpol0 got=%b exp=%b", obs, 7'b0);
    end
    cpol = 1'b1; abort = 1'b1;
    @(posedge clk_in); #1;
    abort = 1'b0;
    n_checks++;
    if (obs !== 7'b1000000) begin
      n_fail++; $display("FAIL idle_cpol1_abort got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  task automatic test_rst_mid();
    div_val = 8'd3; nbits = 6'd4; cpol = 1'b1; cpha = 1'b0; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (7) @(posedge clk_in);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid_async got=%b exp=%b", obs, 7'b0);
    end
    @(posedge clk_in); #1;
    rst = 1'b0;
    @(posedge clk_in); #1;
    n_checks++;
    if (obs !== 7'b1000000) begin
      n_fail++; $display("FAIL rst_mid_release got=%b exp=%b", obs, 7'b1000000);
    end
    run_burst("rst_mid_next", 3, 4, 1'b1, 1'b0, 0, 0, 1, 1'b0);
  endtask

  task automatic test_modes();
    run_burst("mode0_div4_n8", 4, 8, 1'b0, 1'b0, 0, 0, 2, 1'b0);
    run_burst("mode3_div0_n3", 0, 3, 1'b1, 1'b1, 0, 0, 2, 1'b1);
    run_burst("nbits0", 5, 0, 1'b1, 1'b0, 0, 0, 2, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_burst("start_ignored", 2, 4, 1'b0, 1'b1, 0, 10, 3, 1'b0);
  endtask

  task automatic test_abort();
    run_burst("abort_mode2", 3, 4, 1'b1, 1'b0, 9, 0, 2, 1'b0);
    run_burst("abort_restart", 3, 2, 1'b1, 1'b0, 0, 0, 1, 1'b0);
    run_burst("abort_in_done", 2, 2, 1'b0, 1'b0, 9, 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 1, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    run_burst("b2b_b", 2, 1, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    run_burst("b2b_c", 1, 3, 1'b0, 1'b0, 0, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    int dv, nb, ab, tail;
    bit cp, ch;
    for (int i = 0; i < 30; i++) begin
      dv   = $urandom_range(0, 6);
      nb   = $urandom_range(0, 9);
      cp   = 1'($urandom);
      ch   = 1'($urandom);
      tail = $urandom_range(0, 3);
      ab   = 0;
      if ($urandom_range(0, 2) == 0)
        ab = $urandom_range(1, 2 * nb * ((dv == 0) ? 1 : dv) + 1);
      run_burst("random", dv, nb, cp, ch, ab, -1, tail, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_follow();
    test_modes();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
